sbuf_seq_ctrl: RTL and testbench
================================

Name: sbuf_seq_ctrl

Overview:
Controller for one 16-bit 1r1w systolic buffer RAM (registered read address, 1-cycle read latency, synchronous write).
- Sequences a burst of reads into one systolic-array row input, with a programmable skew delay and a stall input.
- Arbitrates the single RAM write port between the host loader and the result writeback path.
- Sits between the top-level scheduler/host and the buffer RAM instance.

Parameters:
DATA_W, 16, RAM word width
RADR_W, 8, RAM read address width (256 entries)
WADR_W, 10, RAM write address width
SKEW_W, 4, width of the skew-count input

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  1-cycle pulse; launches a read burst
base_adr  in  RADR_W  first read address, sampled on an accepted start
len_m1  in  RADR_W  burst length minus 1 (burst of 1..256 words), sampled on an accepted start
skew  in  SKEW_W  idle cycles between start acceptance and the first read, sampled on an accepted start
stall  in  1  array back-pressure; holds the read sequence
busy  out  1  high from an accepted start until done
done  out  1  1-cycle pulse after the last word is delivered
row_valid  out  1  row_data is valid this cycle
row_data  out  DATA_W  word to the array row
hw_req  in  1  host write request
hw_adr  in  WADR_W  host write address
hw_data  in  DATA_W  host write data
hw_gnt  out  1  host write accepted (combinational)
rw_req  in  1  result write request
rw_adr  in  WADR_W  result write address
rw_data  in  DATA_W  result write data
rw_gnt  out  1  result write accepted (combinational)
ram_radr  out  RADR_W  to RAM read address
ram_rdata  in  DATA_W  from RAM read data
ram_wen  out  1  to RAM write enable
ram_wadr  out  WADR_W  to RAM write address
ram_wdata  out  DATA_W  to RAM write data

Behaviour:
- Reset (asynchronous, immediate): all of the following clear to 0, and the FSM goes to IDLE.
  - Outputs: busy, done, row_valid, ram_radr, ram_wen, ram_wadr, ram_wdata.
  - Internal: the arbiter priority pointer (0 = host first), rd_issue_d.
- Reset mid-burst aborts the burst. No done pulse is produced.
- FSM states: IDLE, SKEW, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches base_adr, len_m1 and skew, and sets busy=1.
  - Goes to SKEW if skew≠0, otherwise to RUN.
- SKEW:
  - Counts down the latched skew, one per cycle. stall has no effect here.
  - Goes to RUN when the count expires, so there are exactly skew idle cycles.
- RUN:
  - rd_issue = !stall.
  - On each issue, ram_radr receives the current address (base + k, modulo 256, wrapping 255→0) and the word counter increments.
  - During stall, ram_radr holds its value and the counter holds.
  - After issuing word len_m1, goes to DRAIN.
- DRAIN: one cycle waiting for the last read data. Then goes to DONE.
- DONE:
  - done=1 for one cycle, busy drops to 0 in the same cycle, and the FSM returns to IDLE.
  - start is accepted again only from IDLE, i.e. on the cycle after DONE.
- start while busy is ignored (no latch, no error).
- Read data path:
  - ram_radr is a registered output (issue cycle t → address presented in t+1).
  - The RAM registers that address, so data appears at t+2.
  - row_valid = rd_issue delayed 2 cycles. row_data is ram_rdata passed through combinationally.
  - Total latency from issue to row_valid is 2 cycles.
- Write arbiter:
  - Only one requester: it is granted.
  - Both requesting: the requester indicated by the pointer is granted, then the pointer flips to the other requester (round-robin).
  - Pointer is unchanged when there is no contention.
  - Grant is combinational in the request cycle.
  - ram_wen/ram_wadr/ram_wdata are registered from the granted request, so the RAM write occurs 1 cycle after grant.
  - ram_wen=0 when there is no grant. ram_wadr/ram_wdata hold their last value.
- No read/write forwarding: a same-address read and write resolve per RAM semantics. Avoiding such conflicts is the scheduler's responsibility.
- Write arbitration is independent of the read FSM and continues in every state.

Decomposition:
- Shared package sys_pkg: DATA_W/RADR_W/WADR_W constants, FSM state enum (IDLE, SKEW, RUN, DRAIN, DONE).
- One natural sub-module: sbuf_wr_arb (2-way round-robin write arbiter plus registered write port).
- Read FSM and counters stay in sbuf_seq_ctrl.

Test Plan:
- Reset during RUN (len_m1=9, after 3 issues):
  - busy, done, row_valid and ram_wen go to 0 immediately.
  - After release the FSM is in IDLE, and a new start runs cleanly.
- Burst, RAM preloaded ram[i]=i+0x100, start with base=4, len_m1=3, skew=0:
  - row_valid high on cycles 3-6 after start, with row_data 0x104..0x107.
  - done 1 cycle after the last valid.
- Wrap plus skew: base=254, len_m1=3, skew=2:
  - Addresses issued are 254, 255, 0, 1.
  - First row_valid 2 cycles later than the skew=0 case.
- Stall: burst of 4, stall high for 3 cycles after the 2nd issue:
  - ram_radr holds. Exactly 4 row_valid pulses, in order, with a 3-cycle gap.
  - start pulsed mid-burst is ignored.
- Write contention: hw_req and rw_req both high for 4 cycles (hw_adr=0x010, rw_adr=0x020):
  - Grants alternate host, result, host, result.
  - ram_wen high for 4 cycles, with ram_wadr 0x010, 0x020, 0x010, 0x020, each 1 cycle after its grant.
- Lone requester: rw_req only for 3 cycles → rw_gnt every cycle, hw_gnt=0, pointer unchanged.

Source files
------------

// File: rtl/sys_pkg.sv
// Shared constants, FSM state type and write payload for the systolic buffer controller.
package sys_pkg;

  localparam int unsigned DATA_W = 16;  // RAM word width
  localparam int unsigned RADR_W = 8;   // RAM read address width (256 entries)
  localparam int unsigned WADR_W = 10;  // RAM write address width
  localparam int unsigned SKEW_W = 4;   // skew-count input width

  // Read sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SKEW  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  // One RAM write beat
  typedef struct packed {
    logic [WADR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } wr_beat_t;

endpackage

// File: rtl/sbuf_wr_arb.sv
// 2-way round-robin arbiter for the buffer RAM write port, with registered write outputs.
// Ports:
//   clk, rst                     clock, async active-high reset
//   hw_req/hw_adr/hw_data/hw_gnt host loader request, grant (combinational)
//   rw_req/rw_adr/rw_data/rw_gnt result writeback request, grant (combinational)
//   ram_wen/ram_wadr/ram_wdata   registered RAM write port (one cycle after grant)
module sbuf_wr_arb
  import sys_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hw_req,
  input  logic [WADR_W-1:0] hw_adr,
  input  logic [DATA_W-1:0] hw_data,
  output logic              hw_gnt,
  input  logic              rw_req,
  input  logic [WADR_W-1:0] rw_adr,
  input  logic [DATA_W-1:0] rw_data,
  output logic              rw_gnt,
  output logic              ram_wen,
  output logic [WADR_W-1:0] ram_wadr,
  output logic [DATA_W-1:0] ram_wdata
);

  logic     ptr_q, ptr_d;  // 0: host wins next contention, 1: result wins
  logic     wen_q, wen_d;
  wr_beat_t beat_q, beat_d;

  // Grant selection; pointer only moves when both request
  always_comb begin
    hw_gnt = 1'b0;
    rw_gnt = 1'b0;
    ptr_d  = ptr_q;
    wen_d  = 1'b0;
    beat_d = beat_q;
    if (hw_req && rw_req) begin
      hw_gnt = !ptr_q;
      rw_gnt = ptr_q;
      ptr_d  = !ptr_q;
    end else begin
      hw_gnt = hw_req;
      rw_gnt = rw_req;
    end
    if (hw_gnt) begin
      wen_d       = 1'b1;
      beat_d.adr  = hw_adr;
      beat_d.data = hw_data;
    end else if (rw_gnt) begin
      wen_d       = 1'b1;
      beat_d.adr  = rw_adr;
      beat_d.data = rw_data;
    end
  end

  // Pointer and write-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= 1'b0;
      wen_q  <= 1'b0;
      beat_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wen_q  <= wen_d;
      beat_q <= beat_d;
    end
  end

  assign ram_wen   = wen_q;
  assign ram_wadr  = beat_q.adr;
  assign ram_wdata = beat_q.data;

endmodule

// File: rtl/sbuf_seq_ctrl.sv
// Systolic buffer controller: sequences a skewed, stallable read burst from a 1r1w RAM
// into one array row, and arbitrates the RAM write port between host and writeback.
// Ports:
//   clk, rst                         clock, async active-high reset
//   start, base_adr, len_m1, skew    burst launch and parameters (sampled when accepted)
//   stall                            array back-pressure, holds the read sequence
//   busy, done                       burst in progress / 1-cycle completion pulse
//   row_valid, row_data              word to the array row (data passes from ram_rdata)
//   hw_*, rw_*                       host / result write requests and grants
//   ram_radr, ram_rdata              RAM read port (registered address, 1-cycle latency)
//   ram_wen, ram_wadr, ram_wdata     RAM write port
module sbuf_seq_ctrl
  import sys_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RADR_W-1:0] base_adr,
  input  logic [RADR_W-1:0] len_m1,
  input  logic [SKEW_W-1:0] skew,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              row_valid,
  output logic [DATA_W-1:0] row_data,
  input  logic              hw_req,
  input  logic [WADR_W-1:0] hw_adr,
  input  logic [DATA_W-1:0] hw_data,
  output logic              hw_gnt,
  input  logic              rw_req,
  input  logic [WADR_W-1:0] rw_adr,
  input  logic [DATA_W-1:0] rw_data,
  output logic              rw_gnt,
  output logic [RADR_W-1:0] ram_radr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_wen,
  output logic [WADR_W-1:0] ram_wadr,
  output logic [DATA_W-1:0] ram_wdata
);

  seq_state_e        state_q, state_d;
  logic [RADR_W-1:0] base_q, base_d;
  logic [RADR_W-1:0] len_q, len_d;
  logic [RADR_W-1:0] cnt_q, cnt_d;    // words issued so far
  logic [SKEW_W-1:0] skew_q, skew_d;  // remaining idle cycles
  logic [RADR_W-1:0] radr_q, radr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_issue;
  logic              rd_issue_q;      // issue delayed 1 cycle
  logic              row_valid_q;     // issue delayed 2 cycles

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    skew_d   = skew_q;
    radr_d   = radr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_adr;
          len_d   = len_m1;
          skew_d  = skew;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = (skew != '0) ? SKEW : RUN;
        end
      end
      SKEW: begin
        skew_d = skew_q - SKEW_W'(1);
        if (skew_q == SKEW_W'(1)) state_d = RUN;
      end
      RUN: begin
        rd_issue = !stall;
        if (rd_issue) begin
          radr_d = base_q + cnt_q;  // wraps modulo 256
          cnt_d  = cnt_q + RADR_W'(1);
          if (cnt_q == len_q) state_d = DRAIN;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      skew_q      <= '0;
      radr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_issue_q  <= 1'b0;
      row_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      skew_q      <= skew_d;
      radr_q      <= radr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_issue_q  <= rd_issue;
      row_valid_q <= rd_issue_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_radr  = radr_q;
  assign row_valid = row_valid_q;
  assign row_data  = ram_rdata;  // RAM output register already aligns data with row_valid

  sbuf_wr_arb u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .hw_req    (hw_req),
    .hw_adr    (hw_adr),
    .hw_data   (hw_data),
    .hw_gnt    (hw_gnt),
    .rw_req    (rw_req),
    .rw_adr    (rw_adr),
    .rw_data   (rw_data),
    .rw_gnt    (rw_gnt),
    .ram_wen   (ram_wen),
    .ram_wadr  (ram_wadr),
    .ram_wdata (ram_wdata)
  );

endmodule

// File: tb/tb_sbuf_seq_ctrl.sv
// Self-checking bench for sbuf_seq_ctrl with a behavioural RAM and reference model.
module tb_sbuf_seq_ctrl;
  import sys_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [RADR_W-1:0] base_adr;
  logic [RADR_W-1:0] len_m1;
  logic [SKEW_W-1:0] skew;
  logic              stall;
  logic              busy, done, row_valid;
  logic [DATA_W-1:0] row_data;
  logic              hw_req, rw_req, hw_gnt, rw_gnt;
  logic [WADR_W-1:0] hw_adr, rw_adr;
  logic [DATA_W-1:0] hw_data, rw_data;
  logic [RADR_W-1:0] ram_radr;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_wen;
  logic [WADR_W-1:0] ram_wadr;
  logic [DATA_W-1:0] ram_wdata;

  logic              preload;
  logic [DATA_W-1:0] mem [0:1023];

  int checks;
  int errors;

  // Reference-model state
  logic              ptr_m;     // 0: host wins next contention
  logic              ew;
  logic [WADR_W-1:0] ewa;
  logic [DATA_W-1:0] ewd;
  logic [RADR_W-1:0] last_radr;
  int                first_vld;

  sbuf_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .len_m1(len_m1),
    .skew(skew), .stall(stall), .busy(busy), .done(done), .row_valid(row_valid),
    .row_data(row_data), .hw_req(hw_req), .hw_adr(hw_adr), .hw_data(hw_data),
    .hw_gnt(hw_gnt), .rw_req(rw_req), .rw_adr(rw_adr), .rw_data(rw_data),
    .rw_gnt(rw_gnt), .ram_radr(ram_radr), .ram_rdata(ram_rdata), .ram_wen(ram_wen),
    .ram_wadr(ram_wadr), .ram_wdata(ram_wdata)
  );

  always #5 clk = ~clk;

  // Buffer RAM: registered read address, synchronous write
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0100 + 16'(i);
    end else if (ram_wen) begin
      mem[ram_wadr] <= ram_wdata;
    end
    ram_rdata <= mem[{2'b00, ram_radr}];
  end

  // Runs one burst; cycle 0 is the start cycle. Expected timing comes from the
  // rules: first read eligible at 1+skew, stalled cycles skip, data 2 cycles later.
  task automatic run_burst(input logic [7:0] base, input logic [7:0] len, input logic [3:0] sk,
                           input logic [63:0] smask, input int again, input string tag);
    logic        ev [0:399];
    logic [15:0] ed [0:399];
    logic [7:0]  er [0:399];
    logic [7:0]  a;
    logic [7:0]  r;
    logic        st;
    int          k, last, nv;
    r = last_radr;
    k = 0;
    last = 0;
    for (int c = 0; c < 400; c++) begin
      ev[c] = 1'b0;
      ed[c] = '0;
      er[c] = '0;
    end
    for (int c = 0; c < 398; c++) begin
      er[c] = r;
      st = (c < 64) ? smask[c[5:0]] : 1'b0;
      if (c >= 1 + int'(sk) && k <= int'(len) && !st) begin
        a = base + 8'(k);
        r = a;
        ev[c+2] = 1'b1;
        ed[c+2] = 16'h0100 + 16'(a);
        last = c;
        k++;
      end
    end
    nv = 0;
    first_vld = -1;
    for (int c = 0; c <= last + 4; c++) begin
      checks++;
      if (row_valid !== ev[c]) begin
        errors++;
        $display("FAIL %s row_valid cyc %0d got %b exp %b", tag, c, row_valid, ev[c]);
      end
      checks++;
      if (done !== (c == last + 3)) begin
        errors++;
        $display("FAIL %s done cyc %0d got %b exp %b", tag, c, done, (c == last + 3));
      end
      checks++;
      if (busy !== (c >= 1 && c <= last + 2)) begin
        errors++;
        $display("FAIL %s busy cyc %0d got %b exp %b", tag, c, busy, (c >= 1 && c <= last + 2));
      end
      checks++;
      if (ram_radr !== er[c]) begin
        errors++;
        $display("FAIL %s ram_radr cyc %0d got %0d exp %0d", tag, c, ram_radr, er[c]);
      end
      if (row_valid === 1'b1) begin
        nv++;
        if (first_vld < 0) first_vld = c;
      end
      start    = (c == 0 || c == again);
      stall    = (c < 64) ? smask[c[5:0]] : 1'b0;
      base_adr = (c == 0) ? base : 8'($urandom);
      len_m1   = (c == 0) ? len  : 8'($urandom);
      skew     = (c == 0) ? sk   : 4'($urandom);
      #1;
      if (ev[c]) begin
        checks++;
        if (row_data !== ed[c]) begin
          errors++;
          $display("FAIL %s row_data cyc %0d got %h exp %h", tag, c, row_data, ed[c]);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    stall = 1'b0;
    checks++;
    if (nv != int'(len) + 1) begin
      errors++;
      $display("FAIL %s valid_count got %0d exp %0d", tag, nv, int'(len) + 1);
    end
    last_radr = er[last + 4];
  endtask

  // One write-arbitration cycle against the round-robin model
  task automatic wr_cycle(input logic h, input logic r, input logic [9:0] ha, input logic [9:0] ra,
                          input logic [15:0] hd, input logic [15:0] rd, input string tag);
    logic eh, er_;
    hw_req = h; hw_adr = ha; hw_data = hd;
    rw_req = r; rw_adr = ra; rw_data = rd;
    #1;
    if (h && r) begin
      eh    = (ptr_m == 1'b0);
      er_   = !eh;
      ptr_m = !ptr_m;
    end else begin
      eh  = h;
      er_ = r;
    end
    checks++;
    if (hw_gnt !== eh) begin
      errors++;
      $display("FAIL %s hw_gnt got %b exp %b", tag, hw_gnt, eh);
    end
    checks++;
    if (rw_gnt !== er_) begin
      errors++;
      $display("FAIL %s rw_gnt got %b exp %b", tag, rw_gnt, er_);
    end
    if (eh) begin
      ew = 1'b1; ewa = ha; ewd = hd;
    end else if (er_) begin
      ew = 1'b1; ewa = ra; ewd = rd;
    end else begin
      ew = 1'b0;
    end
    @(posedge clk); #1;
    hw_req = 1'b0;
    rw_req = 1'b0;
    checks++;
    if (ram_wen !== ew) begin
      errors++;
      $display("FAIL %s ram_wen got %b exp %b", tag, ram_wen, ew);
    end
    checks++;
    if (ram_wadr !== ewa || ram_wdata !== ewd) begin
      errors++;
      $display("FAIL %s ram_wadr/wdata got %h/%h exp %h/%h", tag, ram_wadr, ram_wdata, ewa, ewd);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy, done, row_valid, ram_wen} !== 4'b0000 || ram_radr !== '0 ||
        ram_wadr !== '0 || ram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_hold got b%b d%b v%b w%b radr %h wadr %h wdata %h",
               busy, done, row_valid, ram_wen, ram_radr, ram_wadr, ram_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, row_valid, ram_wen} !== 4'b0000 || ram_radr !== '0) begin
      errors++;
      $display("FAIL reset_release got b%b d%b v%b w%b radr %h",
               busy, done, row_valid, ram_wen, ram_radr);
    end
    checks++;
    if (hw_gnt !== 1'b0 || rw_gnt !== 1'b0) begin
      errors++;
      $display("FAIL idle_gnt got %b%b exp 00", hw_gnt, rw_gnt);
    end
  endtask

  task automatic test_burst;
    run_burst(8'd4, 8'd3, 4'd0, 64'd0, -1, "burst");
    checks++;
    if (first_vld != 3) begin
      errors++;
      $display("FAIL burst_first_valid got %0d exp 3", first_vld);
    end
  endtask

  task automatic test_wrap_skew;
    run_burst(8'd254, 8'd3, 4'd2, 64'd0, -1, "wrap_skew");
    checks++;
    if (first_vld != 5) begin
      errors++;
      $display("FAIL wrap_skew_first_valid got %0d exp 5", first_vld);
    end
  endtask

  task automatic test_stall;
    // stall on cycles 3..5 (after the 2nd issue), extra start on cycle 4
    run_burst(8'd20, 8'd3, 4'd0, 64'h38, 4, "stall");
  endtask

  task automatic test_boundaries;
    run_burst(8'd9, 8'd0, 4'd15, 64'd0, -1, "len1_skew15");
    run_burst(8'd7, 8'd255, 4'd1, 64'h0000_0000_0000_0F00, 30, "len256");
  endtask

  task automatic test_random_bursts;
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m = {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)};
      run_burst(8'($urandom), 8'($urandom_range(0, 15)), 4'($urandom), m,
                int'($urandom_range(1, 3)), "random");
    end
  endtask

  task automatic test_reset_mid_run;
    start = 1'b1; base_adr = 8'd0; len_m1 = 8'd9; skew = 4'd0;
    @(posedge clk); #1;  // cycle 1
    start = 1'b0;
    @(posedge clk); #1;  // cycle 2
    @(posedge clk); #1;  // cycle 3
    hw_req = 1'b1; hw_adr = 10'h3F0; hw_data = 16'hBEEF;
    @(posedge clk); #1;  // cycle 4: three reads issued
    hw_req = 1'b0;
    checks++;
    if ({busy, row_valid, ram_wen} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset got b%b v%b w%b exp 111", busy, row_valid, ram_wen);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, row_valid, ram_wen} !== 4'b0000 || ram_radr !== '0) begin
      errors++;
      $display("FAIL async_reset got b%b d%b v%b w%b radr %h",
               busy, done, row_valid, ram_wen, ram_radr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_radr = '0; ptr_m = 1'b0; ew = 1'b0; ewa = '0; ewd = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle got d%b b%b exp 00", done, busy);
      end
    end
    run_burst(8'd40, 8'd2, 4'd1, 64'd0, -1, "post_reset");
  endtask

  task automatic test_write_contention;
    for (int i = 0; i < 4; i++)
      wr_cycle(1'b1, 1'b1, 10'h010, 10'h020, 16'($urandom), 16'($urandom), "contend");
    wr_cycle(1'b0, 1'b0, 10'h000, 10'h000, 16'h0, 16'h0, "contend_idle");
  endtask

  task automatic test_lone_requester;
    for (int i = 0; i < 3; i++)
      wr_cycle(1'b0, 1'b1, 10'h000, 10'h030 + 10'(i), 16'h0, 16'($urandom), "lone_rw");
    // pointer must still favour the host
    wr_cycle(1'b1, 1'b1, 10'h040, 10'h050, 16'h1111, 16'h2222, "lone_ptr");
  endtask

  task automatic test_write_random;
    for (int i = 0; i < 40; i++)
      wr_cycle(1'($urandom), 1'($urandom), 10'($urandom), 10'($urandom),
               16'($urandom), 16'($urandom), "wr_random");
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; preload = 1'b1;
    start = 1'b0; base_adr = '0; len_m1 = '0; skew = '0; stall = 1'b0;
    hw_req = 1'b0; hw_adr = '0; hw_data = '0;
    rw_req = 1'b0; rw_adr = '0; rw_data = '0;
    ptr_m = 1'b0; ew = 1'b0; ewa = '0; ewd = '0; last_radr = '0; first_vld = -1;
    @(posedge clk); #1;
    preload = 1'b0;
    test_reset();
    test_burst();
    test_wrap_skew();
    test_stall();
    test_boundaries();
    test_random_bursts();
    test_reset_mid_run();
    test_write_contention();
    test_lone_requester();
    test_write_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
